// File: rtl/winograd_mult_arbiter.sv
// Round-robin arbiter that time-shares one element-serial 6x6 pointwise
// multiplier between NUM_REQ Winograd tile engines. The owner is exposed both
// one-hot (grant) and binary (sel) so the operand and result muxes can be
// steered directly. A watchdog aborts a job whose multiplier never reports
// done and latches a sticky error flag.
module winograd_mult_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   sel,
    output logic [NUM_REQ-1:0] req_done,
    output logic               mult_start,
    input  logic               mult_done,
    input  logic               mult_busy,
    output logic               busy,
    output logic               timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [WD_W-1:0]    watchdog;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] sel_onehot;
    logic               arb_ok;

    // A stale done or a busy multiplier must never be handed to a new owner.
    assign arb_ok = (|req) && !mult_busy && !mult_done;

    // Search upward from rr_ptr with wrap; the first requesting index wins.
    always_comb begin
        int cand_int;
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_int = (int'(rr_ptr) + i) % NUM_REQ;
            cand     = IDX_W'(cand_int);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Pointer moves just past the winner so it cannot win twice in a row
    // while someone else is waiting.
    assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // One-hot decodes of the winner (for grant) and the owner (for req_done).
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
        assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        assign sel_onehot[gi] = (sel == IDX_W'(gi));
    end

    // Sequencer: arbitrate in IDLE, hold start through RUN, wait for the
    // multiplier to drop done in RELEASE before freeing the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            sel         <= '0;
            req_done    <= '0;
            mult_start  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            watchdog    <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (arb_ok && win_found) begin
                        grant      <= win_onehot;
                        sel        <= win_idx;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        watchdog   <= '0;
                        rr_ptr     <= next_ptr;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    watchdog <= watchdog + 1'b1;
                    if (mult_done) begin
                        req_done   <= sel_onehot;
                        mult_start <= 1'b0;
                        state      <= RELEASE;
                    end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        mult_start  <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!mult_done) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant      <= '0;
                    mult_start <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_mult_arbiter.sv
// Self-checking bench for winograd_mult_arbiter: directed scenarios followed
// by randomized request traffic checked against a round-robin reference.
module tb_winograd_mult_arbiter;

    localparam int N = 4;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] req_done;
    logic       mult_start;
    logic       mult_done;
    logic       mult_busy;
    logic       busy;
    logic       timeout_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int stub_delay = 37;
    bit stub_never = 1'b0;
    bit force_busy = 1'b0;
    int model_ptr  = 0;

    int   stub_cnt;
    logic stub_done;

    winograd_mult_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel),
        .req_done(req_done), .mult_start(mult_start), .mult_done(mult_done),
        .mult_busy(mult_busy), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: raises done stub_delay cycles after start rises,
    // holds it until start falls; never finishes when stub_never is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else if (!mult_start) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else if (!stub_never) begin
            if (stub_cnt == stub_delay - 1) stub_done <= 1'b1;
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign mult_done = stub_done;
    assign mult_busy = force_busy | (mult_start & ~stub_done);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference arbitration rule: rotate so rr pointer is at bit 0, take the
    // lowest set bit, rotate back.
    function automatic int rr_pick(input logic [3:0] r, input int ptr);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {r, r} >> ptr;
        rot = dbl[3:0];
        for (int i = 0; i < 4; i++)
            if (rot[i]) return (ptr + i) % 4;
        return -1;
    endfunction

    // Run one complete job: grant, multiply, req_done pulse, release.
    task automatic run_job(input logic [3:0] exp, input int exp_idx, input bit drop,
                           input string tag, input int exp_lat);
        int k;
        k = 0;
        while (grant == 4'b0000 && k < 20) begin tick(); k++; end
        chk({tag, "_grant"}, 32'(grant), 32'(exp));
        chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
        chk({tag, "_sel"}, 32'(sel), 32'(exp_idx));
        chk({tag, "_start"}, 32'(mult_start), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (req_done == 4'b0000 && mult_start === 1'b1 && k < 200) begin tick(); k++; end
        chk({tag, "_done"}, 32'(req_done), 32'(exp));
        chk({tag, "_done_cyc"}, 32'(k), 32'(stub_delay + 1));
        chk({tag, "_start_fall"}, 32'(mult_start), 32'd0);
        if (drop) req = req & ~exp;
        tick();
        chk({tag, "_pulse"}, 32'(req_done), 32'd0);
        chk({tag, "_hold"}, 32'(grant), 32'(exp));
        tick();
        chk({tag, "_free"}, 32'(grant), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int w;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_start", 32'(mult_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // All four requesting continuously: 0,1,2,3,0
        req = 4'b1111;
        run_job(4'b0001, 0, 1'b0, "rr0", 1);
        run_job(4'b0010, 1, 1'b0, "rr1", 1);
        run_job(4'b0100, 2, 1'b0, "rr2", 1);
        run_job(4'b1000, 3, 1'b0, "rr3", 1);
        run_job(4'b0001, 0, 1'b0, "rr4", 1);

        // Pointer now 1: req=1001 serves 3 before 0, then pointer wraps to 0
        req = 4'b1001;
        run_job(4'b1000, 3, 1'b1, "wrap3", 1);
        run_job(4'b0001, 0, 1'b1, "wrap0", 1);

        // Single request with exact timing
        do_reset();
        req = 4'b0010;
        run_job(4'b0010, 1, 1'b1, "single", 1);

        // Hung multiplier: watchdog abort after 64 RUN cycles
        stub_never = 1'b1;
        req = 4'b0001;
        tick();
        chk("to_grant", 32'(grant), 32'b0001);
        k = 0;
        seen = 1'b0;
        while (mult_start === 1'b1 && k < 200) begin
            tick();
            k++;
            if (req_done != 4'b0000) seen = 1'b1;
        end
        chk("to_cycles", 32'(k), 32'd64);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_no_done", 32'(seen), 32'd0);
        chk("to_hold", 32'(grant), 32'b0001);
        tick();
        chk("to_free", 32'(grant), 32'd0);
        stub_never = 1'b0;
        req = 4'b0100;
        run_job(4'b0100, 2, 1'b1, "after_to", 1);
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // mult_busy blocks arbitration
        do_reset();
        chk("busy_terr_clr", 32'(timeout_err), 32'd0);
        force_busy = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_block", 32'(grant), 32'd0);
        end
        force_busy = 1'b0;
        tick();
        chk("busy_grant", 32'(grant), 32'b0001);
        run_job(4'b0001, 0, 1'b1, "busy_job", 0);

        // Asynchronous reset in the middle of RUN
        do_reset();
        req = 4'b0100;
        tick();
        chk("mid_grant", 32'(grant), 32'b0100);
        repeat (18) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_start", 32'(mult_start), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req_done", 32'(req_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("post_rst_grant", 32'(grant), 32'b0100);
        run_job(4'b0100, 2, 1'b1, "post_rst", 0);

        // Randomized traffic against the round-robin reference
        do_reset();
        model_ptr = 0;
        for (int j = 0; j < 40; j++) begin
            req = req | 4'($urandom_range(0, 15));
            if (req == 4'b0000) req = 4'(1 << $urandom_range(0, 3));
            stub_delay = $urandom_range(1, 50);
            w = rr_pick(req, model_ptr);
            run_job(4'(1 << w), w, ($urandom_range(0, 3) != 0), "rand", 1);
            model_ptr = (w + 1) % 4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
